// File: rtl/load_store_unit.sv
// Memory stage: req/gnt/rvalid data-bus master with byte lanes and load extension.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  ld_sel,
  input  logic [1:0]  s_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [31:0] addr_q, wdata_q, ld_data_q;
  logic [2:0]  ld_sel_q;
  logic [1:0]  s_sel_q;
  logic        load_q;
  logic [7:0]  cnt_q;
  logic        ld_valid_q, bus_err_q, misalign_q;

  logic        go, is_ld, ill, mis, to_hit, in_req;
  logic [3:0]  be_d;
  logic [31:0] wd_d, ld_d, rd_sh;
  logic [15:0] half;

  assign go    = start & (mem_read | mem_write);
  assign is_ld = mem_read;
  assign ill   = is_ld ? (ld_sel > 3'd4) : (s_sel == 2'b11);

`ifdef MISALIGN_TRAP_EN
  assign mis = is_ld
    ? (((ld_sel == 3'b001) | (ld_sel == 3'b100)) & addr[0])
      | ((ld_sel == 3'b010) & (|addr[1:0]))
    : ((s_sel == 2'b01) & addr[0])
      | ((s_sel == 2'b10) & (|addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  // Store lanes come from the captured instruction, stable through REQ
  always_comb begin
    be_d = 4'b1111;
    wd_d = wdata_q;
    if (!load_q) begin
      case (s_sel_q)
        2'b00: begin
          be_d = 4'b0001 << addr_q[1:0];
          wd_d = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          be_d = addr_q[1] ? 4'b1100 : 4'b0011;
          wd_d = {2{wdata_q[15:0]}};
        end
        default: begin
          be_d = 4'b1111;
          wd_d = wdata_q;
        end
      endcase
    end
  end

  assign rd_sh = dmem_rdata >> {addr_q[1:0], 3'b000};
  assign half  = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_d = dmem_rdata;
    case (ld_sel_q)
      3'b000:  ld_d = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_d = {{16{half[15]}}, half};
      3'b011:  ld_d = {24'd0, rd_sh[7:0]};
      3'b100:  ld_d = {16'd0, half};
      default: ld_d = dmem_rdata;
    endcase
  end

  assign in_req     = (state_q == REQ);
  assign stall      = ((state_q == IDLE) & go) | in_req | (state_q == WAIT);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & ~load_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = in_req ? be_d : 4'b0000;
  assign dmem_wdata = (in_req & ~load_q) ? wd_d : 32'd0;
  assign ld_valid   = ld_valid_q;
  assign ld_data    = ld_data_q;
  assign bus_err    = bus_err_q;
  assign misalign   = misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      ld_sel_q   <= '0;
      s_sel_q    <= '0;
      load_q     <= 1'b0;
      cnt_q      <= '0;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      ld_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        IDLE: if (go) begin
          addr_q   <= addr;
          wdata_q  <= wdata;
          ld_sel_q <= ld_sel;
          s_sel_q  <= s_sel;
          load_q   <= is_ld;
          cnt_q    <= '0;
          if (ill) begin
            bus_err_q <= 1'b1;
            state_q   <= RESP;
          end else if (mis) begin
            misalign_q <= 1'b1;
            state_q    <= RESP;
          end else begin
            state_q <= REQ;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (dmem_gnt) begin
            state_q <= load_q ? WAIT : RESP;
          end else if (to_hit) begin
            bus_err_q <= 1'b1;
            ld_data_q <= '0;
            state_q   <= RESP;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (dmem_rvalid) begin
            ld_data_q  <= ld_d;
            ld_valid_q <= 1'b1;
            state_q    <= RESP;
          end else if (to_hit) begin
            bus_err_q <= 1'b1;
            ld_data_q <= '0;
            state_q   <= RESP;
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, timeout, reset.
// Built with TIMEOUT_CYC=8 so a 5-cycle gnt stall stays legal.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mem_read, mem_write;
  logic [2:0]  ld_sel;
  logic [1:0]  s_sel;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, bus_err, misalign;
  logic [31:0] ld_data;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_read(mem_read), .mem_write(mem_write),
    .ld_sel(ld_sel), .s_sel(s_sel),
    .addr(addr), .wdata(wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .bus_err(bus_err), .misalign(misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    start = 0; mem_read = 0; mem_write = 0;
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  task automatic issue_ld(input logic [2:0] sel,
                          input logic [31:0] a);
    start = 1; mem_read = 1; mem_write = 0;
    ld_sel = sel; addr = a;
  endtask

  // back-to-back gnt/rvalid load, checks ld_data in RESP
  task automatic do_load(input string tag,
                         input logic [2:0] sel,
                         input logic [31:0] a,
                         input logic [31:0] rd,
                         input logic [31:0] exp);
    issue_ld(sel, a);
    tick; idle_in; dmem_gnt = 1;
    #1 chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    tick; idle_in; dmem_rvalid = 1; dmem_rdata = rd;
    tick; idle_in;
    #1 chk({tag, "_vld"}, {31'd0, ld_valid}, 32'd1);
    chk({tag, "_data"}, ld_data, exp);
    tick;
  endtask

  initial begin
    rst = 1; idle_in;
    ld_sel = 0; s_sel = 0; addr = 0; wdata = 0; dmem_rdata = 0;
    #12;
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_out", {28'd0, stall, ld_valid, bus_err, misalign}, 32'd0);
    chk("rst_ld_data", ld_data, 32'd0);
    rst = 0;
    tick;

    // lw 0x100, latency check
    issue_ld(3'b010, 32'h100);
    #1 chk("lw_stall0", {31'd0, stall}, 32'd1);
    tick; idle_in; dmem_gnt = 1;
    #1 chk("lw_req1", {30'd0, dmem_req, dmem_we}, 32'd2);
    chk("lw_stall1", {31'd0, stall}, 32'd1);
    chk("lw_addr", dmem_addr, 32'h100);
    tick; idle_in; dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("lw_stall2", {31'd0, stall}, 32'd1);
    chk("lw_req2", {31'd0, dmem_req}, 32'd0);
    tick; idle_in;
    #1 chk("lw_vld3", {31'd0, ld_valid}, 32'd1);
    chk("lw_data", ld_data, 32'hDEADBEEF);
    chk("lw_stall3", {31'd0, stall}, 32'd0);
    tick;
    #1 chk("lw_vld4", {31'd0, ld_valid}, 32'd0);
    chk("lw_hold", ld_data, 32'hDEADBEEF);

    do_load("lb", 3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 3'b011, 32'h103, 32'h80112233, 32'h00000080);
    do_load("lhu", 3'b100, 32'h102, 32'h80112233, 32'h00008011);
    do_load("lh", 3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
    do_load("lb1", 3'b000, 32'h101, 32'h80112233, 32'h00000022);

    // sh with gnt held off for 5 cycles
    start = 1; mem_write = 1; mem_read = 0;
    s_sel = 2'b01; addr = 32'h206; wdata = 32'h1234ABCD;
    tick; idle_in;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) dmem_gnt = 1;
      #1 chk("sh_req", {31'd0, dmem_req}, 32'd1);
      chk("sh_we", {31'd0, dmem_we}, 32'd1);
      chk("sh_addr", dmem_addr, 32'h204);
      chk("sh_be", {28'd0, dmem_be}, 32'hC);
      chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
      tick;
    end
    idle_in;
    #1 chk("sh_resp_req", {31'd0, dmem_req}, 32'd0);
    chk("sh_resp_flags", {29'd0, ld_valid, bus_err, stall}, 32'd0);
    chk("sh_ld_hold", ld_data, 32'hFFFFFF80 & 32'h00000022 | 32'h00000022);
    tick;

    // sb lane replication
    start = 1; mem_write = 1; s_sel = 2'b00; addr = 32'h301; wdata = 32'hAABBCC77;
    tick; idle_in; dmem_gnt = 1;
    #1 chk("sb_be", {28'd0, dmem_be}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h77777777);
    tick; idle_in; tick;

    // sw full word
    start = 1; mem_write = 1; s_sel = 2'b10; addr = 32'h308; wdata = 32'h01020304;
    tick; idle_in; dmem_gnt = 1;
    #1 chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h01020304);
    tick; idle_in; tick;

    // timeout: no gnt for 8 REQ cycles
    issue_ld(3'b010, 32'h400);
    tick; idle_in;
    for (int i = 0; i < 8; i++) begin
      #1 chk("to_req", {31'd0, dmem_req}, 32'd1);
      tick;
    end
    #1 chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
    chk("to_vld", {31'd0, ld_valid}, 32'd0);
    chk("to_data", ld_data, 32'd0);
    tick;
    #1 chk("to_err_pulse", {31'd0, bus_err}, 32'd0);

    // illegal ld_sel
    issue_ld(3'b111, 32'h500);
    #1 chk("ill_stall", {31'd0, stall}, 32'd1);
    tick; idle_in;
    #1 chk("ill_err", {31'd0, bus_err}, 32'd1);
    chk("ill_req", {31'd0, dmem_req}, 32'd0);
    tick;

    // illegal s_sel
    start = 1; mem_write = 1; s_sel = 2'b11; addr = 32'h500;
    tick; idle_in;
    #1 chk("ills_err", {31'd0, bus_err}, 32'd1);
    chk("ills_req", {31'd0, dmem_req}, 32'd0);
    tick;

    // lw at misaligned address
    issue_ld(3'b010, 32'h102);
    tick; idle_in;
`ifdef MISALIGN_TRAP_EN
    #1 chk("mis_flag", {31'd0, misalign}, 32'd1);
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    tick;
`else
    dmem_gnt = 1;
    #1 chk("mis_flag", {31'd0, misalign}, 32'd0);
    chk("mis_addr", dmem_addr, 32'h100);
    tick; idle_in; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
    tick; idle_in;
    #1 chk("mis_data", ld_data, 32'hCAFEF00D);
    tick;
`endif

    // reset during WAIT, then a late rvalid
    issue_ld(3'b010, 32'h600);
    tick; idle_in; dmem_gnt = 1;
    tick; idle_in;
    rst = 1;
    #1 chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_out", {28'd0, stall, ld_valid, bus_err, misalign}, 32'd0);
    chk("rw_data", ld_data, 32'd0);
    tick;
    rst = 0; dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    tick; dmem_rvalid = 0;
    #1 chk("late_vld", {31'd0, ld_valid}, 32'd0);
    tick;
    #1 chk("late_vld2", {31'd0, ld_valid}, 32'd0);
    chk("late_data", ld_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
